// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a registered valid/ready output stage.
// Define ALU_MDU_EN to add the iterative RV32M multiply/divide engine (1 bit per cycle).
module alu_exec_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [6:0]      Opcode,
  input  logic [2:0]      Funct3,
  input  logic [6:0]      Funct7,
  input  logic [XLEN-1:0] OperandA,
  input  logic [XLEN-1:0] OperandB,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic            Busy
);

  localparam logic [6:0] OpcReg = 7'b0110011;
  localparam logic [6:0] OpcImm = 7'b0010011;
  localparam logic [6:0] OpcLui = 7'b0110111;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic              is_r, is_i, accept, is_mop;

  assign is_r    = (Opcode == OpcReg);
  assign is_i    = (Opcode == OpcImm);
  assign shamt   = OperandB[SHAMT_W-1:0];
  assign InReady = (state_q == StIdle) && !Flush && (!out_valid_q || OutReady);
  assign accept  = InValid && InReady;

  // Single-cycle base ALU; anything that is not OP/OP-IMM/LUI computes an address-style ADD.
  always_comb begin
    alu_res = OperandA + OperandB;
    if (Opcode == OpcLui) begin
      alu_res = OperandB;
    end else if (is_r || is_i) begin
      unique case (Funct3)
        3'b000: if (is_r && Funct7 == 7'b0100000) alu_res = OperandA - OperandB;
        3'b001: alu_res = OperandA << shamt;
        3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(OperandA) < $signed(OperandB)};
        3'b011: alu_res = {{(XLEN-1){1'b0}}, OperandA < OperandB};
        3'b100: alu_res = OperandA ^ OperandB;
        3'b101: begin
          if (is_r ? (Funct7 == 7'b0100000) : Funct7[5]) begin
            alu_res = $signed(OperandA) >>> shamt;
          end else begin
            alu_res = OperandA >> shamt;
          end
        end
        3'b110: alu_res = OperandA | OperandB;
        default: alu_res = OperandA & OperandB;
      endcase
    end
  end

`ifdef ALU_MDU_EN
  // acc_q holds {hi, lo}: product during multiply, {remainder, quotient} during divide.
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod_full;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]   a_mag, b_mag, quo_rem, mdu_res;
  logic [XLEN:0]     step_sum, rem_sh, rem_diff;
  logic              sgn_a, sgn_b, a_neg, b_neg, neg_in;

  assign is_mop = is_r && (Funct7 == 7'b0000001);
  assign Busy   = (state_q == StCalc);

  // Signed ops run on magnitudes; the sign is reapplied once the iteration finishes.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (Funct3)
      3'b001, 3'b100, 3'b110: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'b010:  sgn_a = 1'b1;
      default: ;
    endcase
    a_neg = sgn_a & OperandA[XLEN-1];
    b_neg = sgn_b & OperandB[XLEN-1];
    a_mag = a_neg ? -OperandA : OperandA;
    b_mag = b_neg ? -OperandB : OperandB;
    if (!Funct3[2]) begin
      neg_in = a_neg ^ b_neg;
    end else if (!Funct3[1]) begin
      // Divide by zero leaves the all-ones quotient unsigned.
      neg_in = (a_neg ^ b_neg) & (|OperandB);
    end else begin
      neg_in = a_neg;
    end
  end

  always_comb begin
    step_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, dvs_q};
    if (!op_q[2]) begin
      acc_step = {step_sum, acc_q[XLEN-1:1]};
    end else if (!rem_diff[XLEN]) begin
      acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
    prod_full = neg_q ? -acc_q : acc_q;
    quo_rem   = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (!op_q[2]) begin
      mdu_res = (op_q[1:0] == 2'b00) ? prod_full[XLEN-1:0] : prod_full[2*XLEN-1:XLEN];
    end else begin
      mdu_res = neg_q ? -quo_rem : quo_rem;
    end
  end
`else
  assign is_mop = 1'b0;
  assign Busy   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
`ifdef ALU_MDU_EN
    acc_d = acc_q;
    dvs_d = dvs_q;
    op_d  = op_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
`endif
    if (Flush) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_mop) begin
              state_d     = StCalc;
              out_valid_d = 1'b0;
`ifdef ALU_MDU_EN
              acc_d = {{XLEN{1'b0}}, a_mag};
              dvs_d = b_mag;
              op_d  = Funct3;
              neg_d = neg_in;
              cnt_d = '0;
`endif
            end else begin
              result_d    = alu_res;
              out_valid_d = 1'b1;
            end
          end else if (out_valid_q && OutReady) begin
            out_valid_d = 1'b0;
          end
        end
`ifdef ALU_MDU_EN
        StCalc: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHAMT_W'(XLEN - 1)) state_d = StDone;
        end
        StDone: begin
          if (!out_valid_q) begin
            result_d    = mdu_res;
            out_valid_d = 1'b1;
          end else if (OutReady) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef ALU_MDU_EN
      acc_q <= '0;
      dvs_q <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
`ifdef ALU_MDU_EN
      acc_q <= acc_d;
      dvs_q <= dvs_d;
      op_q  <= op_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
`endif
    end
  end

  assign OutValid = out_valid_q;
  assign Result   = result_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed literal cases, then random traffic checked every cycle
// against a behavioural model. M-extension cases are compiled in when ALU_MDU_EN is defined.
module tb_alu_exec_unit;

  logic        clk = 1'b0, rst_n = 1'b1, Flush = 1'b0, InValid = 1'b0, OutReady = 1'b1;
  logic [6:0]  Opcode = '0, Funct7 = '0;
  logic [2:0]  Funct3 = '0;
  logic [31:0] OperandA = '0, OperandB = '0;
  logic        InReady, OutValid, Busy;
  logic [31:0] Result;

  int n_checks = 0, n_pass = 0;
  bit chk_en = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7), .OperandA(OperandA),
    .OperandB(OperandB), .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_m(input logic [6:0] op, input logic [6:0] f7);
`ifdef ALU_MDU_EN
    return (op == 7'h33) && (f7 == 7'h01);
`else
    return 1'b0;
`endif
  endfunction

  // Reference result straight from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p, ua, ub;
    logic [4:0]  sh;
    bit          r, i;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    sh = b[4:0];
    r  = (op == 7'h33);
    i  = (op == 7'h13);
    if (is_m(op, f7)) begin
      case (f3)
        3'd0: begin p = ua * ub; return p[31:0]; end
        3'd1: begin p = sa * sb; return p[63:32]; end
        3'd2: begin p = sa * longint'(ub); return p[63:32]; end
        3'd3: begin p = ua * ub; return p[63:32]; end
        3'd4: begin
          if (b == 0) return 32'hFFFFFFFF;
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
          p = sa / sb; return p[31:0];
        end
        3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
        3'd6: begin
          if (b == 0) return a;
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
          p = sa % sb; return p[31:0];
        end
        default: return (b == 0) ? a : a % b;
      endcase
    end
    if (op == 7'h37) return b;
    if (!(r || i)) return a + b;
    case (f3)
      3'd0: return (r && f7 == 7'h20) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return (r ? (f7 == 7'h20) : f7[5]) ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Behavioural timing model: pending M op counts down XLEN+1 edges to its result.
  bit          exp_valid = 0, m_pending = 0, acc_m = 0;
  int          m_left = 0;
  logic [31:0] exp_result = '0, m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid = 0;
      m_pending = 0;
      m_left    = 0;
    end else begin
      acc_m = InValid && !m_pending && !Flush && (!exp_valid || OutReady);
      if (Flush) begin
        exp_valid = 0;
        m_pending = 0;
      end else if (m_pending) begin
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            exp_valid  = 1;
            exp_result = m_res;
          end
        end else if (exp_valid && OutReady) begin
          exp_valid = 0;
          m_pending = 0;
        end
      end else if (acc_m) begin
        if (is_m(Opcode, Funct7)) begin
          m_pending = 1;
          m_left    = 33;
          exp_valid = 0;
          m_res     = ref_alu(Opcode, Funct3, Funct7, OperandA, OperandB);
        end else begin
          exp_valid  = 1;
          exp_result = ref_alu(Opcode, Funct3, Funct7, OperandA, OperandB);
        end
      end else if (exp_valid && OutReady) begin
        exp_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_ready", InReady, !m_pending && !Flush && (!exp_valid || OutReady));
      chk("out_valid", OutValid, exp_valid);
      chk("busy", Busy, m_pending && m_left > 1);
      if (exp_valid) chk("result", Result, exp_result);
    end
  end

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    Opcode = op; Funct3 = f3; Funct7 = f7; OperandA = a; OperandB = b; InValid = 1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (InReady) begin
        @(posedge clk);
        done = 1;
      end
    end
    #1 InValid = 0;
    chk("send_accepted", done, 1);
  endtask

  task automatic wait_out(output logic [31:0] r, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (OutValid) break;
      if (Busy) busy_cnt++;
      lat++;
    end
    r = Result;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] r;
  int lat, busy_cnt;

  initial begin
    #2 rst_n = 0;
    #20;
    @(posedge clk);
    #3 rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_result", Result, 32'h0);
    chk("rst_valid", OutValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_inready", InReady, 1);

    // ADD then SUB back-to-back at full rate
    @(posedge clk);
    #1 Opcode = 7'h33; Funct3 = 0; Funct7 = 0; OperandA = 5; OperandB = 7; InValid = 1;
    @(posedge clk);
    #1 Funct7 = 7'h20; OperandA = 3; OperandB = 5;
    @(negedge clk);
    chk("add", Result, 32'd12);
    chk("add_valid", OutValid, 1);
    @(posedge clk);
    #1 InValid = 0;
    @(negedge clk);
    chk("sub", Result, 32'hFFFFFFFE);

    send(7'h13, 3'd5, 7'h20, 32'h80000000, 32'd4);
    @(negedge clk) chk("srai", Result, 32'hF8000000);
    send(7'h13, 3'd5, 7'h00, 32'h80000000, 32'd4);
    @(negedge clk) chk("srli", Result, 32'h08000000);
    send(7'h33, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF);
    @(negedge clk) chk("sltu", Result, 32'd1);
    send(7'h33, 3'd2, 7'h00, 32'd1, 32'hFFFFFFFF);
    @(negedge clk) chk("slt", Result, 32'd0);
    send(7'h33, 3'd1, 7'h00, 32'd1, 32'h25);
    @(negedge clk) chk("sll_shamt", Result, 32'h20);
    send(7'h37, 3'd0, 7'h00, 32'h11, 32'h12345000);
    @(negedge clk) chk("lui", Result, 32'h12345000);
    send(7'h63, 3'd0, 7'h20, 32'd10, 32'd6);
    @(negedge clk) chk("branch_add", Result, 32'd16);
`ifndef ALU_MDU_EN
    send(7'h33, 3'd0, 7'h01, 32'd5, 32'd7);
    @(negedge clk) chk("f7_01_add", Result, 32'd12);
`endif

    // Output stall: result held, no accept until OutReady returns
    @(posedge clk);
    #1 OutReady = 0;
    send(7'h33, 3'd0, 7'h00, 32'd100, 32'd23);
    Opcode = 7'h33; Funct3 = 3'd4; Funct7 = 0; OperandA = 32'hF0F0F0F0;
    OperandB = 32'hFF00FF00; InValid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_result", Result, 32'd123);
      chk("stall_valid", OutValid, 1);
      chk("stall_inready", InReady, 0);
    end
    @(posedge clk);
    #1 OutReady = 1;
    @(negedge clk) chk("stall_release", InReady, 1);
    @(posedge clk);
    #1 InValid = 0;
    @(negedge clk) chk("xor_after_stall", Result, 32'h0FF00FF0);

`ifdef ALU_MDU_EN
    send(7'h33, 3'd0, 7'h01, 32'd6, 32'd7);
    wait_out(r, lat, busy_cnt);
    chk("mul_result", r, 32'd42);
    chk("mul_latency", lat, 33);
    chk("mul_busy_cycles", busy_cnt, 32);
    send(7'h33, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF);
    wait_out(r, lat, busy_cnt);
    chk("div_ovf", r, 32'h80000000);
    send(7'h33, 3'd5, 7'h01, 32'd1234, 32'd0);
    wait_out(r, lat, busy_cnt);
    chk("divu_zero", r, 32'hFFFFFFFF);
    send(7'h33, 3'd6, 7'h01, 32'd9, 32'd0);
    wait_out(r, lat, busy_cnt);
    chk("rem_zero", r, 32'd9);
    send(7'h33, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2);
    wait_out(r, lat, busy_cnt);
    chk("div_neg", r, 32'hFFFFFFFD);

    // Flush mid-calculation
    send(7'h33, 3'd5, 7'h01, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 Flush = 1;
    @(negedge clk) chk("flush_inready", InReady, 0);
    @(posedge clk);
    #1 Flush = 0;
    @(negedge clk);
    chk("flush_busy", Busy, 0);
    chk("flush_valid", OutValid, 0);
    chk("flush_inready_after", InReady, 1);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-calculation
    send(7'h33, 3'd0, 7'h01, 32'd3, 32'd3);
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_valid", OutValid, 0);
    chk("arst_result", Result, 32'h0);
    @(posedge clk);
    #3 rst_n = 1;
`endif

    // Random traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      InValid  = ($urandom_range(0, 99) < 60);
      OutReady = ($urandom_range(0, 99) < 75);
      Flush    = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 7))
        0, 1, 2: Opcode = 7'h33;
        3, 4:    Opcode = 7'h13;
        5:       Opcode = 7'h37;
        6:       Opcode = 7'h03;
        default: Opcode = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: Funct7 = 7'h00;
        1: Funct7 = 7'h20;
        2: Funct7 = 7'h01;
        default: Funct7 = 7'($urandom);
      endcase
      Funct3   = 3'($urandom);
      OperandA = rand_val();
      OperandB = rand_val();
    end
    @(posedge clk);
    #1 InValid = 0; Flush = 0; OutReady = 1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
